// File: rtl/ps2_evt_if.sv
// Event pop handshake between the PS/2 key decoder and its consumer.
// master drives data/valid, slave drives ready.
interface ps2_evt_if;
  logic [9:0] evt_data;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    output evt_data,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_data,
    input  evt_valid,
    output evt_ready
  );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scancode prefix decoder, key map, held bitmap and event FIFO.
// Optional macro PS2_REPEAT_FILTER_EN drops typematic repeat makes.
module ps2_key_event_decoder #(
  parameter  int NUM_KEYS = 4,
  parameter  int DEPTH    = 8,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                inclock,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  ps2_evt_if.master           evt,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [7:0]          last_data_received,
  output logic [ADDR_W:0]     fifo_count,
  output logic                overflow,
  input  logic                clr_overflow
);

  typedef enum logic [1:0] {
    IDLE, GOT_E0, GOT_F0, GOT_E0F0
  } state_t;

  function automatic logic [7:0] scan_of(input int i);
    case (i)
      0: scan_of = 8'h15;
      1: scan_of = 8'h1D;
      2: scan_of = 8'h24;
      3: scan_of = 8'h2D;
      4: scan_of = 8'h1C;
      5: scan_of = 8'h1B;
      6: scan_of = 8'h23;
      default: scan_of = 8'h2B;
    endcase
  endfunction

  function automatic logic [7:0] ascii_of(input int i);
    case (i)
      0: ascii_of = 8'h51;
      1: ascii_of = 8'h57;
      2: ascii_of = 8'h45;
      3: ascii_of = 8'h52;
      4: ascii_of = 8'h41;
      5: ascii_of = 8'h53;
      6: ascii_of = 8'h44;
      default: ascii_of = 8'h46;
    endcase
  endfunction

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t                r_state, w_next;
  logic                  w_make, w_brk;
  logic                  w_hit;
  logic [NUM_KEYS-1:0]   w_mask;
  logic [7:0]            w_ascii;
  logic                  w_rep, w_mk, w_bk;
  logic                  w_push, w_pop, w_full;
  logic                  w_wr, w_drop;
  logic [NUM_KEYS-1:0]   r_held;
  logic [7:0]            r_last;
  logic                  r_ovf;
  logic [9:0]            r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr, r_rd;
  logic [ADDR_W:0]       r_count;

  always_comb begin
    w_next = r_state;
    w_make = 1'b0;
    w_brk  = 1'b0;
    if (rx_valid) begin
      case (r_state)
        IDLE: begin
          if (rx_data == 8'hE0)      w_next = GOT_E0;
          else if (rx_data == 8'hF0) w_next = GOT_F0;
          else if (rx_data != 8'hAA && rx_data != 8'hFA &&
                   rx_data != 8'hEE && rx_data != 8'hFE)
            w_make = 1'b1;
        end
        GOT_E0: begin
          if (rx_data == 8'hF0)      w_next = GOT_E0F0;
          else if (rx_data != 8'hE0) w_next = IDLE;
        end
        GOT_F0: begin
          if (rx_data == 8'hE0)      w_next = GOT_E0;
          else if (rx_data != 8'hF0) begin
            w_next = IDLE;
            w_brk  = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_hit   = 1'b0;
    w_mask  = '0;
    w_ascii = 8'h00;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rx_data == scan_of(i)) begin
        w_hit     = 1'b1;
        w_mask[i] = 1'b1;
        w_ascii   = ascii_of(i);
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  assign w_rep = |(r_held & w_mask);
`else
  assign w_rep = 1'b0;
`endif

  assign w_mk   = w_make && w_hit && !w_rep;
  assign w_bk   = w_brk && w_hit;
  assign w_push = w_mk || w_bk;
  assign w_pop  = (r_count != '0) && evt.evt_ready;
  assign w_full = (r_count == FULL);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge inclock) begin
    if (reset) begin
      r_state <= IDLE;
      r_held  <= '0;
      r_last  <= 8'h00;
      r_ovf   <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_mk) begin
        r_held <= r_held | w_mask;
        r_last <= w_ascii;
      end else if (w_bk) begin
        r_held <= r_held & ~w_mask;
      end
      // a drop outranks a simultaneous clear
      if (w_drop)            r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge inclock) begin
    if (w_wr) r_mem[r_wr] <= {w_bk, 1'b0, w_ascii};
  end

  assign evt.evt_valid      = (r_count != '0);
  assign evt.evt_data       = evt.evt_valid ? r_mem[r_rd] : 10'h000;
  assign key_held           = r_held;
  assign last_data_received = r_last;
  assign fifo_count         = r_count;
  assign overflow           = r_ovf;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed plus random bench for ps2_key_event_decoder against a
// queue-based reference model of the key event rules.
module tb_ps2_key_event_decoder;
  localparam int NK = 4;
  localparam int DP = 8;
  localparam int AW = $clog2(DP);

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [NK-1:0] key_held;
  logic [7:0]    last_data_received;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          clr_overflow;

  ps2_evt_if evt_if ();

  ps2_key_event_decoder #(.NUM_KEYS(NK), .DEPTH(DP)) dut (
    .inclock            (clk),
    .reset              (reset),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid),
    .evt                (evt_if),
    .key_held           (key_held),
    .last_data_received (last_data_received),
    .fifo_count         (fifo_count),
    .overflow           (overflow),
    .clr_overflow       (clr_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] scan_t [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D,
                             8'h1C, 8'h1B, 8'h23, 8'h2B};
  logic [7:0] asc_t  [8] = '{8'h51, 8'h57, 8'h45, 8'h52,
                             8'h41, 8'h53, 8'h44, 8'h46};
  logic [7:0] pool   [12] = '{8'h15, 8'h1D, 8'h24, 8'h2D,
                              8'h1C, 8'hE0, 8'hF0, 8'hF0,
                              8'hAA, 8'h6B, 8'hFA, 8'hE0};

  logic [9:0] mq [$];
  bit [NK-1:0] m_held;
  logic [7:0]  m_last;
  bit          m_ovf;
  bit          m_e0, m_f0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all;
    logic [9:0] head;
    head = (mq.size() != 0) ? mq[0] : 10'h000;
    chk("evt_valid", 32'(evt_if.evt_valid), 32'(mq.size() != 0));
    chk("evt_data", 32'(evt_if.evt_data), 32'(head));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("key_held", 32'(key_held), 32'(m_held));
    chk("last_data", 32'(last_data_received), 32'(m_last));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic model(input bit rst, input bit v, input logic [7:0] d,
                       input bit rdy, input bit clr);
    bit pop, mk, bk, hit, push, drop;
    int k;
    logic [9:0] rec;
    if (rst) begin
      mq.delete();
      m_held = '0; m_last = 8'h00; m_ovf = 1'b0;
      m_e0 = 1'b0; m_f0 = 1'b0;
      return;
    end
    pop = (mq.size() != 0) && rdy;
    mk = 0; bk = 0; push = 0; hit = 0; k = 0; rec = '0;
    if (v) begin
      if (m_e0 && m_f0) begin
        m_e0 = 0; m_f0 = 0;
      end else if (m_e0) begin
        if (d == 8'hF0) m_f0 = 1;
        else if (d != 8'hE0) m_e0 = 0;
      end else if (m_f0) begin
        if (d == 8'hE0) begin m_e0 = 1; m_f0 = 0; end
        else if (d != 8'hF0) begin bk = 1; m_f0 = 0; end
      end else begin
        if (d == 8'hE0) m_e0 = 1;
        else if (d == 8'hF0) m_f0 = 1;
        else if (!(d inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) mk = 1;
      end
    end
    for (int i = 0; i < NK; i++)
      if (scan_t[i] == d) begin hit = 1; k = i; end
    if (mk && hit) begin
`ifdef PS2_REPEAT_FILTER_EN
      if (!m_held[k]) begin
        m_held[k] = 1; m_last = asc_t[k]; push = 1; rec = {2'b00, asc_t[k]};
      end
`else
      m_held[k] = 1; m_last = asc_t[k]; push = 1; rec = {2'b00, asc_t[k]};
`endif
    end
    if (bk && hit) begin
      m_held[k] = 0; push = 1; rec = {2'b10, asc_t[k]};
    end
    drop = push && (mq.size() == DP) && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !drop) mq.push_back(rec);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic step(input bit rst, input bit v, input logic [7:0] d,
                      input bit rdy, input bit clr);
    @(negedge clk);
    check_all();
    reset = rst; rx_valid = v; rx_data = d;
    evt_if.evt_ready = rdy; clr_overflow = clr;
    model(rst, v, d, rdy, clr);
    @(posedge clk);
  endtask

  task automatic byte_in(input logic [7:0] d);
    step(0, 1, d, 0, 0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(0, 0, 8'h00, 1, 0);
  endtask

  initial begin
    reset = 1; rx_valid = 0; rx_data = 0;
    evt_if.evt_ready = 0; clr_overflow = 0;
    model(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    step(0, 0, 8'h00, 0, 0);

    byte_in(8'h15); step(0, 0, 8'h00, 0, 0);
    byte_in(8'hF0); byte_in(8'h15); drain(4);

    byte_in(8'hE0); byte_in(8'h15);
    byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h15);
    byte_in(8'h6B); byte_in(8'hAA); byte_in(8'hFA);
    byte_in(8'h1D); drain(3);

    byte_in(8'h1C); byte_in(8'hF0); byte_in(8'h1C); drain(2);

    byte_in(8'h15); byte_in(8'hF0); byte_in(8'h15);
    byte_in(8'h1D); byte_in(8'hF0); byte_in(8'h1D);
    byte_in(8'h24); byte_in(8'hF0); byte_in(8'h24);
    byte_in(8'h2D); byte_in(8'hF0); byte_in(8'h2D);
    byte_in(8'h15); step(0, 0, 8'h00, 0, 0);
    step(0, 1, 8'h1D, 1, 0);
    step(0, 0, 8'h00, 0, 1);
    drain(10);

    byte_in(8'h24); byte_in(8'h24); byte_in(8'h24);
    byte_in(8'hF0); byte_in(8'h24); drain(6);

    byte_in(8'hF0); step(1, 0, 8'h00, 0, 0);
    byte_in(8'h2D); drain(2);
    byte_in(8'hF0); byte_in(8'h2D); drain(2);

    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) :
          pool[$urandom_range(0, 11)];
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, b,
           $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end
    drain(12);
    step(0, 0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
Consumes the byte stream from PS2_Controller (received_data / received_data_en), runs a prefix state machine for 0xE0/0xF0, and maps up to 8 scancodes to ASCII. Produces make/break events into a parametrised FIFO with a valid/ready pop interface. Keeps a per-key held bitmap and the last pressed character. Successor to the fixed Q/W/E/R latch in PS2_Interface; sits between PS2_Controller and the processor/IO bus.

Parameters:
NUM_KEYS, 4, number of mapped keys, 1..8; uses the first NUM_KEYS table entries.
DEPTH, 8, event FIFO depth; power of two, 2..64.
ADDR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
inclock  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  scancode byte from PS2_Controller.
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
evt_data  output  10  FIFO head: {break, 1'b0, ascii[7:0]}. Bit 8 is reserved and always 0.
evt_valid  output  1  FIFO non-empty.
evt_ready  input  1  consumer pop; pop occurs when evt_valid && evt_ready.
key_held  output  NUM_KEYS  bit i is high while table key i is held.
last_data_received  output  8  ASCII of the most recent accepted make event.
fifo_count  output  ADDR_W+1  number of entries, 0..DEPTH.
overflow  output  1  sticky; set when an event is dropped because the FIFO is full.
clr_overflow  input  1  clears overflow synchronously.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; pointers 0. Reset mid-sequence discards a pending prefix. Reset overrides every other input.
- Map table, index: scancode -> ASCII:
  - 0: 0x15 -> 0x51 (Q)
  - 1: 0x1D -> 0x57 (W)
  - 2: 0x24 -> 0x45 (E)
  - 3: 0x2D -> 0x52 (R)
  - 4: 0x1C -> 0x41 (A)
  - 5: 0x1B -> 0x53 (S)
  - 6: 0x23 -> 0x44 (D)
  - 7: 0x2B -> 0x46 (F)
  - Codes outside the first NUM_KEYS entries are unmapped.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Bytes are processed only on rx_valid.
  - IDLE:
    - 0xE0 -> GOT_E0.
    - 0xF0 -> GOT_F0.
    - 0xAA, 0xFA, 0xEE, 0xFE are ignored and the FSM stays in IDLE.
    - Any other byte is a make event for that byte; FSM stays in IDLE.
  - GOT_E0:
    - 0xF0 -> GOT_E0F0.
    - 0xE0 -> stay in GOT_E0.
    - Any other byte is an extended make; it is discarded and the FSM returns to IDLE.
  - GOT_F0:
    - 0xF0 -> stay in GOT_F0.
    - 0xE0 -> GOT_E0 (resync).
    - Any other byte is a break event for that byte; FSM returns to IDLE.
  - GOT_E0F0: any byte is an extended break; it is discarded and the FSM returns to IDLE.
- Events on unmapped codes are discarded with no side effects.
- Mapped make:
  - key_held[i] is set.
  - last_data_received <= ascii.
  - Push {0, 0, ascii}, subject to the repeat filter.
- Mapped break:
  - key_held[i] is cleared.
  - Push {1, 0, ascii}.
  - last_data_received is unchanged.
- Latency: an rx_valid byte in cycle N that completes an event updates key_held and last_data_received at the end of cycle N. The FIFO write also happens at the end of cycle N, so evt_valid and evt_data are visible in cycle N+1. There is no bypass path from input to output.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - fifo_count tracks pushes minus pops.
  - Pop when empty is ignored.
  - Push when full, with no pop in the same cycle: the event is dropped, overflow is set, and key_held and last_data_received still update.
  - Push and pop in the same cycle when full: both occur and the count stays at DEPTH.
  - Push and pop in the same cycle when non-empty: the count is unchanged.
- overflow:
  - clr_overflow clears it.
  - If a drop and clr_overflow occur in the same cycle, overflow stays set.

Optional Feature:
PS2_REPEAT_FILTER_EN
- Defined: a mapped make whose key_held bit is already 1 (typematic repeat) is not pushed. key_held and last_data_received are unchanged by it.
- Undefined: every mapped make is pushed, including repeats.

Test Plan:
1. Reset, then bytes 0x15, F0 15 -> FIFO pops 0x051 then 0x251. last_data_received=0x51. key_held[0] goes 1 then 0. evt_valid first high the cycle after the 0x15 strobe.
2. Bytes E0 15, E0 F0 15, 0x6B, AA, FA -> no events, key_held=0, FSM back in IDLE; a following 0x1D yields 0x057.
3. With NUM_KEYS=4, bytes 0x1C then F0 1C -> no events. With NUM_KEYS=8, the same bytes give 0x041 and 0x241.
4. DEPTH=8, evt_ready=0, 9 make/break events -> fifo_count=8, overflow=1, the 9th event is lost. A push with simultaneous pop at full keeps count=8. clr_overflow clears the flag.
5. Bytes 0x24, 0x24, 0x24, F0 24 -> 4 events without PS2_REPEAT_FILTER_EN, 2 events (0x045, 0x245) with it.
6. Reset asserted after F0 and before 0x2D, then 0x2D -> 0x052 is pushed as a make, not a break.
